// File: rtl/vga_timing_pkg.sv
// Shared raster defaults, coordinate width and the sync/blank bundle that
// travels down the pixel-pipeline delay line.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE_DFLT = 640;
  localparam int H_FRONT_DFLT   = 16;
  localparam int H_SYNC_DFLT    = 96;
  localparam int H_BACK_DFLT    = 48;
  localparam int H_TOTAL_DFLT   = H_VISIBLE_DFLT + H_FRONT_DFLT + H_SYNC_DFLT + H_BACK_DFLT;

  localparam int V_VISIBLE_DFLT = 480;
  localparam int V_FRONT_DFLT   = 10;
  localparam int V_SYNC_DFLT    = 2;
  localparam int V_BACK_DFLT    = 33;
  localparam int V_TOTAL_DFLT   = V_VISIBLE_DFLT + V_FRONT_DFLT + V_SYNC_DFLT + V_BACK_DFLT;

  localparam int PIPE_DELAY_DFLT = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } vga_ctrl_t;

  // Idle state of the pins: syncs deasserted (high), no active video.
  localparam vga_ctrl_t CTRL_RST = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  // True when pos lies in [first, first+len-1].
  function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                     input int first, input int len);
    int p;
    p = int'(pos);
    return (p >= first) && (p < first + len);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Async-reset shift register that re-times sync/blank to match renderer RGB
// latency. DEPTH=0 collapses to a plain wire.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int               WIDTH   = $bits(vga_ctrl_t),
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic g_unused;
      assign g_unused = clk_i ^ rst_ni;
      assign data_o   = data_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift stages one place per cycle; reset parks every stage at the idle value.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
          stage_q[0] <= data_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign data_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters exposed as DrawX/DrawY, sync and
// blank decoded from them and delayed to line up with renderer RGB, plus a
// per-frame strobe and frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DFLT,
  parameter int H_FRONT    = H_FRONT_DFLT,
  parameter int H_SYNC     = H_SYNC_DFLT,
  parameter int H_BACK     = H_BACK_DFLT,
  parameter int V_VISIBLE  = V_VISIBLE_DFLT,
  parameter int V_FRONT    = V_FRONT_DFLT,
  parameter int V_SYNC     = V_SYNC_DFLT,
  parameter int V_BACK     = V_BACK_DFLT,
  parameter int PIPE_DELAY = PIPE_DELAY_DFLT
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               frame_start,
  output logic [7:0]         frame_count
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int VS_FIRST = V_VISIBLE + V_FRONT;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  logic [COORD_W-1:0] hcnt_q, hcnt_d;
  logic [COORD_W-1:0] vcnt_q, vcnt_d;
  logic               frame_start_q, frame_start_d;
  logic [7:0]         frame_count_q, frame_count_d;
  logic               h_wrap, v_wrap, frame_wrap;
  vga_ctrl_t          ctrl_raw, ctrl_dly;

  // Next raster position; the last pixel of the last line returns to (0,0).
  always_comb begin
    h_wrap     = (hcnt_q == H_LAST);
    v_wrap     = (vcnt_q == V_LAST);
    frame_wrap = h_wrap && v_wrap;
    hcnt_d     = hcnt_q + 1'b1;
    vcnt_d     = vcnt_q;
    if (h_wrap) begin
      hcnt_d = '0;
      vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
    end
  end

  // Frame strobe lands on the same edge that moves the raster to (0,0), so it
  // is high exactly while DrawX/DrawY read (0,0) and the count steps with it.
  always_comb begin
    frame_start_d = frame_wrap;
    frame_count_d = frame_count_q + {7'd0, frame_wrap};
  end

  // Raster and frame registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Undelayed sync/blank decode, aligned with DrawX/DrawY.
  always_comb begin
    ctrl_raw.hs    = !in_window(hcnt_q, HS_FIRST, H_SYNC);
    ctrl_raw.vs    = !in_window(vcnt_q, VS_FIRST, V_SYNC);
    ctrl_raw.blank = in_window(hcnt_q, 0, H_VISIBLE) && in_window(vcnt_q, 0, V_VISIBLE);
  end

  vga_delay_line #(
    .WIDTH   ($bits(vga_ctrl_t)),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (CTRL_RST)
  ) u_ctrl_dly (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .data_i (ctrl_raw),
    .data_o (ctrl_dly)
  );

  assign DrawX       = hcnt_q;
  assign DrawY       = vcnt_q;
  assign hs          = ctrl_dly.hs;
  assign vs          = ctrl_dly.vs;
  assign blank       = ctrl_dly.blank;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (so that 256+ frames fit in a
// short run), with two instances: PIPE_DELAY=2 and PIPE_DELAY=0. Expected
// values come from a cycle-index reference: position, sync and frame count
// are computed arithmetically from the number of clock edges since reset.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VV = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FT = HT * VT;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] x2, y2, x0, y0;
  logic       hs2, vs2, bl2, fs2, hs0, vs0, bl0, fs0;
  logic [7:0] fc2, fc0;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .PIPE_DELAY(2)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x2), .DrawY(y2),
    .hs(hs2), .vs(vs2), .blank(bl2), .frame_start(fs2), .frame_count(fc2)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .PIPE_DELAY(0)
  ) dut0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x0), .DrawY(y0),
    .hs(hs0), .vs(vs0), .blank(bl0), .frame_start(fs0), .frame_count(fc0)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", tag, t, obs, exp);
    end
  endtask

  // Reference: what the pins should show tt edges after reset release.
  function automatic void ref_at(input int tt, input int pd,
                                 output int x, output int y,
                                 output int h, output int v, output int b,
                                 output int fs, output int fc);
    int u, ux, uy;
    x  = tt % HT;
    y  = (tt / HT) % VT;
    fc = (tt / FT) % 256;
    fs = (tt > 0 && (tt % FT) == 0) ? 1 : 0;
    if (tt < pd) begin
      h = 1; v = 1; b = 0;
    end else begin
      u  = tt - pd;
      ux = u % HT;
      uy = (u / HT) % VT;
      h  = (ux >= HV + HF && ux < HV + HF + HSW) ? 0 : 1;
      v  = (uy >= VV + VF && uy < VV + VF + VSW) ? 0 : 1;
      b  = (ux < HV && uy < VV) ? 1 : 0;
    end
  endfunction

  task automatic check_all(input int tt);
    int x, y, h, v, b, fs, fc;
    ref_at(tt, 2, x, y, h, v, b, fs, fc);
    check_val("d2_drawx", int'(x2), x);
    check_val("d2_drawy", int'(y2), y);
    check_val("d2_hs", int'(hs2), h);
    check_val("d2_vs", int'(vs2), v);
    check_val("d2_blank", int'(bl2), b);
    check_val("d2_fstart", int'(fs2), fs);
    check_val("d2_fcount", int'(fc2), fc);
    ref_at(tt, 0, x, y, h, v, b, fs, fc);
    check_val("d0_drawx", int'(x0), x);
    check_val("d0_hs", int'(hs0), h);
    check_val("d0_vs", int'(vs0), v);
    check_val("d0_blank", int'(bl0), b);
    check_val("d0_fcount", int'(fc0), fc);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge vga_clk);
      t++;
      check_all(t);
    end
  endtask

  // Called just after a negedge: drop reset mid-cycle, verify the outputs
  // cleared with no clock edge, hold a while, then release at a negedge.
  task automatic async_reset(input int dly, input int hold);
    #(dly);
    reset_n = 1'b0;
    #1;
    t = 0;
    check_all(0);
    repeat (hold) begin
      @(negedge vga_clk);
      check_all(0);
    end
    reset_n = 1'b1;
    t = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    check_all(0);
    reset_n = 1'b1;
    t = 0;

    // Reach column 11 of line 2, inside the hsync window, then reset.
    run_cycles(2 * HT + 11);
    check_val("mid_hs_raw_low", int'(hs0), 0);
    async_reset(2, 2);

    // Past 256 frames so the frame counter wraps back to zero.
    run_cycles(256 * FT + 37);
    check_val("fc_wrapped", int'(fc2), 0);

    repeat (6) begin
      run_cycles($urandom_range(20, 700));
      async_reset($urandom_range(1, 4), $urandom_range(1, 4));
    end
    run_cycles(FT + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
